// File: rtl/scr1_tapc_sampled.sv
// JTAG TAP controller clocked by the system clock. tck/tms/tdi are oversampled and
// edge-detected; user DR channels are exposed as one-hot selects with strobes.
module scr1_tapc_sampled #(
  parameter int unsigned          IR_WIDTH     = 5,
  parameter logic [31:0]          IDCODE_VAL   = 32'hDEB11001,
  parameter logic [31:0]          BLD_ID_VAL   = 32'h22011200,
  parameter int unsigned          DR_CH_NUM    = 2,
  parameter logic [IR_WIDTH-1:0]  USER_IR_BASE = 5'h10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tck,
  input  logic                 tms,
  input  logic                 tdi,
  output logic                 tdo,
  output logic                 tdo_en,
  output logic [3:0]           tap_state,
  output logic [IR_WIDTH-1:0]  ir_out,
  output logic                 tap_rst,
  output logic [DR_CH_NUM-1:0] dr_ch_sel,
  output logic                 dr_capture,
  output logic                 dr_shift,
  output logic                 dr_update,
  output logic                 dr_tdi,
  input  logic [DR_CH_NUM-1:0] dr_ch_tdo
);

  typedef enum logic [3:0] {
    StReset     = 4'd0,
    StIdle      = 4'd1,
    StDrSelScan = 4'd2,
    StDrCapture = 4'd3,
    StDrShift   = 4'd4,
    StDrExit1   = 4'd5,
    StDrPause   = 4'd6,
    StDrExit2   = 4'd7,
    StDrUpdate  = 4'd8,
    StIrSelScan = 4'd9,
    StIrCapture = 4'd10,
    StIrShift   = 4'd11,
    StIrExit1   = 4'd12,
    StIrPause   = 4'd13,
    StIrExit2   = 4'd14,
    StIrUpdate  = 4'd15
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IrIdcode = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IrBldId  = IR_WIDTH'(4);

  logic tck_s1_q, tck_s2_q, tck_q;
  logic tms_s1_q, tms_s2_q;
  logic tdi_s1_q, tdi_s2_q;

  tap_state_e           state_q, state_d, state_nxt;
  logic [IR_WIDTH-1:0]  ir_q, ir_d, ir_sh_q, ir_sh_d, ir_off;
  logic [31:0]          dr_sh_q, dr_sh_d;
  logic                 tdo_q, tdo_d, tdo_en_q, tdo_en_d, tap_rst_q, tap_rst_d;
  logic [DR_CH_NUM-1:0] dr_ch_sel_q, dr_ch_sel_d;
  logic                 tck_rise, tck_fall, user_sel, ch_tdo, cap, shf, upd;

  assign tck_rise = tck_s2_q & ~tck_q;
  assign tck_fall = ~tck_s2_q & tck_q;
  assign user_sel = |dr_ch_sel_q;
  assign ch_tdo   = |(dr_ch_tdo & dr_ch_sel_q);

  // IEEE 1149.1 transition on the synchronised tms
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      StReset:     state_nxt = tms_s2_q ? StReset     : StIdle;
      StIdle:      state_nxt = tms_s2_q ? StDrSelScan : StIdle;
      StDrSelScan: state_nxt = tms_s2_q ? StIrSelScan : StDrCapture;
      StDrCapture: state_nxt = tms_s2_q ? StDrExit1   : StDrShift;
      StDrShift:   state_nxt = tms_s2_q ? StDrExit1   : StDrShift;
      StDrExit1:   state_nxt = tms_s2_q ? StDrUpdate  : StDrPause;
      StDrPause:   state_nxt = tms_s2_q ? StDrExit2   : StDrPause;
      StDrExit2:   state_nxt = tms_s2_q ? StDrUpdate  : StDrShift;
      StDrUpdate:  state_nxt = tms_s2_q ? StDrSelScan : StIdle;
      StIrSelScan: state_nxt = tms_s2_q ? StReset     : StIrCapture;
      StIrCapture: state_nxt = tms_s2_q ? StIrExit1   : StIrShift;
      StIrShift:   state_nxt = tms_s2_q ? StIrExit1   : StIrShift;
      StIrExit1:   state_nxt = tms_s2_q ? StIrUpdate  : StIrPause;
      StIrPause:   state_nxt = tms_s2_q ? StIrExit2   : StIrPause;
      StIrExit2:   state_nxt = tms_s2_q ? StIrUpdate  : StIrShift;
      StIrUpdate:  state_nxt = tms_s2_q ? StDrSelScan : StIdle;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    ir_sh_d  = ir_sh_q;
    dr_sh_d  = dr_sh_q;
    tdo_d    = tdo_q;
    tdo_en_d = tdo_en_q;
    cap      = 1'b0;
    shf      = 1'b0;
    upd      = 1'b0;

    if (tck_rise) begin
      case (state_q)
        StIrCapture: ir_sh_d = IR_WIDTH'(1);
        StIrShift:   ir_sh_d = {tdi_s2_q, ir_sh_q[IR_WIDTH-1:1]};
        StDrCapture: begin
          if (user_sel)               cap     = 1'b1;
          else if (ir_q == IrIdcode)  dr_sh_d = IDCODE_VAL;
          else if (ir_q == IrBldId)   dr_sh_d = BLD_ID_VAL;
          else                        dr_sh_d = '0;
        end
        StDrShift: begin
          if (user_sel) shf = 1'b1;
          else if ((ir_q == IrIdcode) || (ir_q == IrBldId)) dr_sh_d = {tdi_s2_q, dr_sh_q[31:1]};
          else dr_sh_d[0] = tdi_s2_q;
        end
        default: ;
      endcase
      state_d = state_nxt;
    end

    if (tck_fall) begin
      if (state_q == StIrUpdate) ir_d = ir_sh_q;
      if (state_q == StDrUpdate) upd = user_sel;
      if (state_q == StIrShift) begin
        tdo_d    = ir_sh_q[0];
        tdo_en_d = 1'b1;
      end else if (state_q == StDrShift) begin
        tdo_d    = user_sel ? ch_tdo : dr_sh_q[0];
        tdo_en_d = 1'b1;
      end else begin
        tdo_en_d = 1'b0;
      end
    end

    if (state_q == StReset) ir_d = IrIdcode;
    tap_rst_d = (state_d == StReset);

    // Channel select follows the instruction; out-of-range offsets wrap and miss
    ir_off      = ir_d - USER_IR_BASE;
    dr_ch_sel_d = '0;
    for (int unsigned i = 0; i < DR_CH_NUM; i++) begin
      if (ir_off == IR_WIDTH'(i)) dr_ch_sel_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tck_s1_q    <= 1'b0;
      tck_s2_q    <= 1'b0;
      tck_q       <= 1'b0;
      tms_s1_q    <= 1'b0;
      tms_s2_q    <= 1'b0;
      tdi_s1_q    <= 1'b0;
      tdi_s2_q    <= 1'b0;
      state_q     <= StReset;
      ir_q        <= IrIdcode;
      ir_sh_q     <= '0;
      dr_sh_q     <= '0;
      tdo_q       <= 1'b0;
      tdo_en_q    <= 1'b0;
      tap_rst_q   <= 1'b1;
      dr_ch_sel_q <= '0;
    end else begin
      tck_s1_q    <= tck;
      tck_s2_q    <= tck_s1_q;
      tck_q       <= tck_s2_q;
      tms_s1_q    <= tms;
      tms_s2_q    <= tms_s1_q;
      tdi_s1_q    <= tdi;
      tdi_s2_q    <= tdi_s1_q;
      state_q     <= state_d;
      ir_q        <= ir_d;
      ir_sh_q     <= ir_sh_d;
      dr_sh_q     <= dr_sh_d;
      tdo_q       <= tdo_d;
      tdo_en_q    <= tdo_en_d;
      tap_rst_q   <= tap_rst_d;
      dr_ch_sel_q <= dr_ch_sel_d;
    end
  end

  assign tdo        = tdo_q;
  assign tdo_en     = tdo_en_q;
  assign tap_state  = state_q;
  assign ir_out     = ir_q;
  assign tap_rst    = tap_rst_q;
  assign dr_ch_sel  = dr_ch_sel_q;
  assign dr_capture = cap & ~rst;
  assign dr_shift   = shf & ~rst;
  assign dr_update  = upd & ~rst;
  assign dr_tdi     = tdi_s2_q;

endmodule

// File: tb/tb_scr1_tapc_sampled.sv
// Directed bench for scr1_tapc_sampled: tdo/dr_tdi expectations queued at drive time and
// popped when the DUT presents them; strobe counts and tck width are monitored alongside.
module tb_scr1_tapc_sampled;

  localparam logic [3:0] SReset = 4'd0, SIdle = 4'd1, SDrCapture = 4'd3, SDrShift = 4'd4;
  localparam logic [3:0] SDrExit1 = 4'd5;

  logic       clk = 1'b0;
  logic       rst, tck, tms, tdi;
  logic       tdo, tdo_en, tap_rst, dr_capture, dr_shift, dr_update, dr_tdi;
  logic [3:0] tap_state;
  logic [4:0] ir_out;
  logic [1:0] dr_ch_sel, dr_ch_tdo;

  int vectors = 0;
  int miscompares = 0;
  int n_cap = 0, n_shf = 0, n_upd = 0;
  int tck_viol = 0, tck_run = 100;
  logic tck_prev = 1'b0;

  logic exp_q[$];
  logic tdi_q[$];

  scr1_tapc_sampled dut (
    .clk        (clk),
    .rst        (rst),
    .tck        (tck),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .tdo_en     (tdo_en),
    .tap_state  (tap_state),
    .ir_out     (ir_out),
    .tap_rst    (tap_rst),
    .dr_ch_sel  (dr_ch_sel),
    .dr_capture (dr_capture),
    .dr_shift   (dr_shift),
    .dr_update  (dr_update),
    .dr_tdi     (dr_tdi),
    .dr_ch_tdo  (dr_ch_tdo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full tck period: tms/tdi set up, 4 clk high, 4 clk low
  task automatic tck_pulse(input logic m, input logic d);
    tms = m;
    tdi = d;
    clks(1);
    tck = 1'b1;
    clks(4);
    tck = 1'b0;
    clks(4);
  endtask

  task automatic check_tdo(input string tag);
    logic e;
    chk({tag, "_queue"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(tag, 32'(tdo), 32'(e));
      chk({tag, "_en"}, 32'(tdo_en), 32'd1);
    end
  endtask

  task automatic ir_scan(input logic [4:0] v);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    exp_q.push_back(1'b1);
    tck_pulse(1'b0, 1'b0);
    check_tdo("ir_shift_tdo");
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(1'b0);
      tck_pulse(i == 4, v[i]);
      if (i < 4) check_tdo("ir_shift_tdo");
    end
    chk("ir_exit_tdo_en", 32'(tdo_en), 32'd0);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    chk("ir_scan_idle", 32'(tap_state), 32'(SIdle));
  endtask

  always @(negedge clk) begin
    if (dr_capture) n_cap++;
    if (dr_update) n_upd++;
    if (dr_shift) begin
      n_shf++;
      chk("dr_tdi_queue", 32'(tdi_q.size() != 0), 32'd1);
      if (tdi_q.size() != 0) chk("dr_tdi", 32'(dr_tdi), 32'(tdi_q.pop_front()));
    end
  end

  // Pad-level tck run length in clk cycles; runs shorter than 3 are violations
  always @(posedge clk) begin
    if (tck !== tck_prev) begin
      if (tck_run < 3) tck_viol <= tck_viol + 1;
      tck_run  <= 1;
      tck_prev <= tck;
    end else begin
      tck_run <= tck_run + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] idc;
    logic [7:0]  pat, chp;
    logic [3:0]  byp;
    idc = 32'hDEB11001;
    pat = 8'hB4;
    chp = 8'h5C;
    byp = 4'b1101;

    rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; dr_ch_tdo = 2'b00;
    clks(2);
    chk("rst_state", 32'(tap_state), 32'(SReset));
    chk("rst_ir", 32'(ir_out), 32'h01);
    chk("rst_tdo_en", 32'(tdo_en), 32'd0);
    chk("rst_tdo", 32'(tdo), 32'd0);
    chk("rst_tap_rst", 32'(tap_rst), 32'd1);
    chk("rst_sel", 32'(dr_ch_sel), 32'd0);
    rst = 1'b0;
    clks(2);

    repeat (5) tck_pulse(1'b1, 1'b0);
    chk("tms1_state", 32'(tap_state), 32'(SReset));
    chk("tms1_tap_rst", 32'(tap_rst), 32'd1);

    // IDCODE readout
    tck_pulse(1'b0, 1'b0);
    chk("idle_state", 32'(tap_state), 32'(SIdle));
    chk("idle_tap_rst", 32'(tap_rst), 32'd0);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    chk("dr_capture_state", 32'(tap_state), 32'(SDrCapture));
    exp_q.push_back(idc[0]);
    tck_pulse(1'b0, 1'b0);
    check_tdo("idcode_tdo");
    for (int i = 1; i < 32; i++) begin
      exp_q.push_back(idc[i]);
      tck_pulse(1'b0, 1'($urandom_range(0, 1)));
      check_tdo("idcode_tdo");
    end
    tck_pulse(1'b1, 1'b0);
    chk("idcode_exit_state", 32'(tap_state), 32'(SDrExit1));
    chk("idcode_exit_tdo_en", 32'(tdo_en), 32'd0);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);

    // User channel 1
    ir_scan(5'h11);
    chk("ch1_ir", 32'(ir_out), 32'h11);
    chk("ch1_sel", 32'(dr_ch_sel), 32'h2);
    n_cap = 0; n_shf = 0; n_upd = 0;
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    dr_ch_tdo = {chp[0], ~chp[0]};
    exp_q.push_back(chp[0]);
    tck_pulse(1'b0, 1'b0);
    check_tdo("ch1_tdo");
    for (int i = 0; i < 8; i++) begin
      tdi_q.push_back(pat[i]);
      if (i < 7) begin
        dr_ch_tdo = {chp[i+1], ~chp[i+1]};
        exp_q.push_back(chp[i+1]);
      end
      tck_pulse(i == 7, pat[i]);
      if (i < 7) check_tdo("ch1_tdo");
    end
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    chk("ch1_capture_cnt", 32'(n_cap), 32'd1);
    chk("ch1_shift_cnt", 32'(n_shf), 32'd8);
    chk("ch1_update_cnt", 32'(n_upd), 32'd1);

    // Unused code acts as BYPASS
    ir_scan(5'h0A);
    chk("byp_ir", 32'(ir_out), 32'h0A);
    chk("byp_sel", 32'(dr_ch_sel), 32'd0);
    n_cap = 0; n_shf = 0; n_upd = 0;
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    exp_q.push_back(1'b0);
    tck_pulse(1'b0, 1'b0);
    check_tdo("byp_tdo");
    for (int i = 0; i < 4; i++) begin
      if (i < 3) exp_q.push_back(byp[i]);
      tck_pulse(i == 3, byp[i]);
      if (i < 3) check_tdo("byp_tdo");
    end
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    chk("byp_strobes", 32'(n_cap + n_shf + n_upd), 32'd0);

    // Reset in the middle of a channel 0 shift
    ir_scan(5'h10);
    chk("ch0_sel", 32'(dr_ch_sel), 32'h1);
    n_cap = 0; n_shf = 0; n_upd = 0;
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0);
    tdi_q.push_back(1'b1);
    tck_pulse(1'b0, 1'b1);
    tdi_q.push_back(1'b0);
    tck_pulse(1'b0, 1'b0);
    chk("ch0_shift_state", 32'(tap_state), 32'(SDrShift));
    chk("ch0_shift_cnt", 32'(n_shf), 32'd2);
    rst = 1'b1;
    clks(1);
    chk("midrst_state", 32'(tap_state), 32'(SReset));
    chk("midrst_sel", 32'(dr_ch_sel), 32'd0);
    chk("midrst_ir", 32'(ir_out), 32'h01);
    chk("midrst_tap_rst", 32'(tap_rst), 32'd1);
    rst = 1'b0;
    tms = 1'b1;
    clks(2);
    rst = 1'b1;
    tck = 1'b1;
    clks(4);
    chk("rst_vs_rise_state", 32'(tap_state), 32'(SReset));
    rst = 1'b0;
    clks(4);
    tck = 1'b0;
    clks(10);
    chk("after_rst_state", 32'(tap_state), 32'(SReset));
    chk("after_rst_update_cnt", 32'(n_upd), 32'd0);
    chk("tdi_q_drained", 32'(tdi_q.size()), 32'd0);

    // tck pulses below the minimum width must be flagged
    chk("tck_width_ok", 32'(tck_viol), 32'd0);
    tck = 1'b1; clks(2);
    tck = 1'b0; clks(2);
    tck = 1'b1; clks(4);
    tck = 1'b0; clks(4);
    chk("tck_width_short", 32'(tck_viol), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
